// File: rtl/rvv_rs_fifo_mwmr.sv
// Multi-write/multi-read reservation-station FIFO with flush, occupancy and sticky error flags.
// Pushes and pops are all-or-nothing per cycle; same-cycle pops never make room for pushes.
module rvv_rs_fifo_mwmr #(
  parameter int unsigned DWIDTH   = 64,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned NUM_POP  = 2,
  parameter int unsigned AFULL_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_PUSH-1:0]          push,
  input  logic [NUM_PUSH*DWIDTH-1:0]   push_data,
  input  logic [NUM_POP-1:0]           pop,
  output logic [NUM_POP*DWIDTH-1:0]    out_data,
  output logic [NUM_POP-1:0]           out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         almost_full,
  output logic                         empty,
  output logic                         ovf_err,
  output logic                         unf_err,
  output logic                         proto_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     free, np, nq;
  logic [NUM_PUSH-1:0] push_inc;
  logic [NUM_POP-1:0]  pop_inc;
  logic              push_therm, pop_therm, push_ok, pop_ok;

  // A vector is thermometer-coded when adding one clears every set bit.
  always_comb begin
    push_inc   = push + NUM_PUSH'(1);
    pop_inc    = pop + NUM_POP'(1);
    push_therm = ((push & push_inc) == '0);
    pop_therm  = ((pop & pop_inc) == '0);
    np = '0;
    for (int unsigned i = 0; i < NUM_PUSH; i++) np = np + CW'(push[i]);
    nq = '0;
    for (int unsigned j = 0; j < NUM_POP; j++) nq = nq + CW'(pop[j]);
    free    = DEPTH_C - count;
    push_ok = push_therm && (np <= free) && !flush;
    pop_ok  = pop_therm && (nq <= count) && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(np);
      if (pop_ok)  rptr <= rptr + PW'(nq);
      count <= count + (push_ok ? np : '0) - (pop_ok ? nq : '0);
      if (push_therm && (np > free))  ovf_err   <= 1'b1;
      if (pop_therm && (nq > count))  unf_err   <= 1'b1;
      if (!push_therm || !pop_therm)  proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int unsigned i = 0; i < NUM_PUSH; i++)
        if (push[i]) mem[wptr + PW'(i)] <= push_data[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int unsigned j = 0; j < NUM_POP; j++) begin
      out_data[j*DWIDTH +: DWIDTH] = mem[rptr + PW'(j)];
      out_valid[j] = (32'(count) > j);
    end
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almost_full = (32'(free) < AFULL_TH);
  end

endmodule
